// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter feeding one UART TX byte port
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BITS   = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_BYTES   = 256,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_valid,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_ready,
  output logic                           grant_valid,
  output logic [ID_W-1:0]                grant_id,
  output logic                           abort,
  output logic [ID_W-1:0]                abort_id
);

  localparam int BW = (MAX_BYTES > 0)   ? $clog2(MAX_BYTES + 1)   : 1;
  localparam int SW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int GW = (GAP_CYCLES > 0)  ? $clog2(GAP_CYCLES + 1)  : 1;
  localparam logic [BW-1:0]   BYTE_CAP  = BW'(MAX_BYTES);
  localparam logic [SW-1:0]   STALL_CAP = SW'(TIMEOUT_CYC);
  localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     grant_id_q, rr_ptr, abort_id_q, pick_id;
  logic                grant_valid_q, abort_q, pick_found;
  logic [BW-1:0]       byte_cnt;
  logic [SW-1:0]       stall_cnt;
  logic [GW-1:0]       gap_cnt;
  logic                g_valid, g_last, xfer, end_pkt, do_abort;
  logic [DATA_BITS-1:0] g_data;

  // First requesting index at or after rr_ptr, wrapping; lowest offset wins.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] idx;
    rr_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (v[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    {pick_found, pick_id} = rr_pick(req_valid, rr_ptr);
  end

  always_comb begin
    g_valid = req_valid[grant_id_q];
    g_last  = req_last[grant_id_q];
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id_q) g_data = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    xfer      = 1'b0;
    end_pkt   = 1'b0;
    do_abort  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) state_nxt = S_XFER;
      end
      S_XFER: begin
        tx_valid              = g_valid;
        tx_data               = g_data;
        req_ready[grant_id_q] = tx_ready;
        xfer                  = g_valid & tx_ready;
        // last takes priority over the length cap on the same byte
        if (xfer && g_last) begin
          end_pkt = 1'b1;
        end else if (xfer && (MAX_BYTES != 0) && (byte_cnt + 1'b1 == BYTE_CAP)) begin
          end_pkt  = 1'b1;
          do_abort = 1'b1;
        end else if (!g_valid && (TIMEOUT_CYC != 0) && (stall_cnt + 1'b1 == STALL_CAP)) begin
          end_pkt  = 1'b1;
          do_abort = 1'b1;
        end
        if (end_pkt) state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr        <= '0;
      byte_cnt      <= '0;
      stall_cnt     <= '0;
      gap_cnt       <= '0;
      abort_q       <= 1'b0;
      abort_id_q    <= '0;
    end else begin
      state   <= state_nxt;
      abort_q <= do_abort;
      if (do_abort) abort_id_q <= grant_id_q;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id_q    <= pick_id;
            grant_valid_q <= 1'b1;
          end
        end
        S_XFER: begin
          if (end_pkt) begin
            rr_ptr        <= (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
            grant_valid_q <= 1'b0;
            byte_cnt      <= '0;
            stall_cnt     <= '0;
            gap_cnt       <= '0;
          end else begin
            if (xfer && (MAX_BYTES != 0)) byte_cnt <= byte_cnt + 1'b1;
            if (g_valid) stall_cnt <= '0;
            else if (TIMEOUT_CYC != 0) stall_cnt <= stall_cnt + 1'b1;
          end
        end
        S_GAP: begin
          gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign abort       = abort_q;
  assign abort_id    = abort_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DB-1:0] req_data;
  logic            tx_valid, tx_ready, grant_valid, abort;
  logic [DB-1:0]   tx_data;
  logic [1:0]      grant_id, abort_id;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_BITS(DB), .GAP_CYCLES(16), .TIMEOUT_CYC(4096), .MAX_BYTES(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant_valid(grant_valid), .grant_id(grant_id),
    .abort(abort), .abort_id(abort_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int id; } xent_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] drv_q [N][$];
  logic [7:0] exp_q [N][$];
  int         exp_grant[$];
  int         exp_abort[$];
  xent_t      xlog[$];
  int         alog[$];
  int         rise_cyc [N];
  int         tx_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input int id, input int n, input int b0, input bit with_last);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(b0 + i);
      drv_q[id].push_back({with_last && (i == n - 1), b});
      exp_q[id].push_back(b);
    end
  endtask

  function automatic int pending();
    int p;
    p = exp_grant.size() + exp_abort.size();
    for (int i = 0; i < N; i++) p += exp_q[i].size();
    return p;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((pending() != 0 || grant_valid) && k < budget) begin
      tick(1);
      k++;
    end
    check({name, "_done_in_budget"}, k < budget, 1);
    tick(20);
  endtask

  // Requester drivers: present queue heads, pop on a handshake seen at the negedge.
  initial begin
    logic [N-1:0] hs;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          if (!req_valid[i]) rise_cyc[i] = cyc;
          req_valid[i]          = 1'b1;
          req_data[i*DB +: DB]  = drv_q[i][0][7:0];
          req_last[i]           = drv_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      tx_ready = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? (cyc % 4 == 0) : 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a byte, grant or abort.
  initial begin
    logic        gv_prev;
    logic [N-1:0] er;
    logic [63:0] e;
    int          id;
    gv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        er = '0;
        if (grant_valid) er[grant_id] = tx_ready;
        check("req_ready", req_ready, er);
        check("tx_valid", tx_valid, grant_valid & req_valid[grant_id]);
        if (grant_valid && !gv_prev) begin
          e = (exp_grant.size() > 0) ? 64'(exp_grant.pop_front()) : 64'hFFFF;
          check("grant_id", grant_id, e);
        end
        if (tx_valid && tx_ready) begin
          id = int'(grant_id);
          e = (exp_q[id].size() > 0) ? 64'(exp_q[id].pop_front()) : 64'h1FF;
          check("tx_data", tx_data, e);
          xlog.push_back('{cyc, id});
        end
        if (abort) begin
          e = (exp_abort.size() > 0) ? 64'(exp_abort.pop_front()) : 64'hFFFF;
          check("abort_id", abort_id, e);
          alog.push_back(cyc);
        end
      end
      gv_prev = grant_valid;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, abase, a0, a1, cnt_before, cnt_after, last_before, last_r1;
    int ids [10];
    ids = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_abort", abort, 0);
    check("rst_abort_id", abort_id, 0);

    // R0 alone, three bytes back to back
    base = xlog.size();
    exp_grant.push_back(0);
    send(0, 3, 'hA1, 1'b1);
    wait_idle("t1", 200);
    check("t1_xfer_count", xlog.size() - base, 3);
    if (xlog.size() >= base + 3) begin
      check("t1_first_latency", xlog[base].cyc - rise_cyc[0], 1);
      check("t1_consec_1", xlog[base+1].cyc - xlog[base].cyc, 1);
      check("t1_consec_2", xlog[base+2].cyc - xlog[base+1].cyc, 1);
    end
    check("t1_no_abort", alog.size(), 0);

    // R0 five bytes with the UART ready one cycle in four
    base = xlog.size();
    tx_mode = 1;
    exp_grant.push_back(0);
    send(0, 5, 'h51, 1'b1);
    wait_idle("t5", 400);
    tx_mode = 0;
    check("t5_xfer_count", xlog.size() - base, 5);
    check("t5_no_abort", alog.size(), 0);

    // R2 sends one byte then stalls; R3 then R1 wait behind it
    base  = xlog.size();
    abase = alog.size();
    exp_grant.push_back(2);
    exp_grant.push_back(3);
    exp_grant.push_back(1);
    exp_abort.push_back(2);
    send(2, 1, 'hC0, 1'b0);
    tick(3);
    send(3, 2, 'h30, 1'b1);
    send(1, 1, 'h10, 1'b1);
    wait_idle("t3", 6000);
    check("t3_abort_count", alog.size() - abase, 1);
    if (alog.size() > abase && xlog.size() > base) begin
      check("t3_stall_byte_id", xlog[base].id, 2);
      check("t3_abort_latency", alog[abase] - xlog[base].cyc, 4097);
    end

    // R1 streams 300 bytes with no last; R2 arrives while R1 is granted
    base  = xlog.size();
    abase = alog.size();
    exp_grant.push_back(1);
    exp_grant.push_back(2);
    exp_grant.push_back(1);
    exp_abort.push_back(1);
    exp_abort.push_back(1);
    send(1, 300, 0, 1'b0);
    tick(3);
    send(2, 2, 'h20, 1'b1);
    wait_idle("t4", 10000);
    check("t4_abort_count", alog.size() - abase, 2);
    if (alog.size() >= abase + 2) begin
      a0 = alog[abase];
      a1 = alog[abase+1];
      cnt_before = 0; cnt_after = 0; last_before = 0; last_r1 = 0;
      for (int k = base; k < xlog.size(); k++) begin
        if (xlog[k].id == 1) begin
          if (xlog[k].cyc < a0) begin
            cnt_before++;
            last_before = xlog[k].cyc;
          end else begin
            cnt_after++;
          end
          last_r1 = xlog[k].cyc;
        end
      end
      check("t4_bytes_before_cap", cnt_before, 256);
      check("t4_cap_abort_latency", a0 - last_before, 1);
      check("t4_bytes_after_cap", cnt_after, 44);
      check("t4_timeout_latency", a1 - last_r1, 4097);
    end

    // Reset for one cycle in the middle of an R1 packet
    base = xlog.size();
    exp_grant.push_back(1);
    send(1, 6, 'h60, 1'b1);
    for (int k = 0; k < 50 && xlog.size() < base + 2; k++) tick(1);
    check("t6_two_bytes_before_reset", xlog.size() - base, 2);
    tx_mode  = 2;
    tx_ready = 1'b0;
    rst_n    = 1'b0;
    drv_q[1].delete();
    exp_q[1].delete();
    tick(1);
    rst_n    = 1'b1;
    tx_mode  = 0;
    tx_ready = 1'b1;
    check("t6_req_ready", req_ready, 0);
    check("t6_tx_valid", tx_valid, 0);
    check("t6_grant_valid", grant_valid, 0);
    check("t6_grant_id", grant_id, 0);
    check("t6_abort", abort, 0);
    check("t6_abort_id", abort_id, 0);
    exp_grant.push_back(0);
    exp_grant.push_back(3);
    send(3, 1, 'h33, 1'b1);
    send(0, 1, 'h03, 1'b1);
    wait_idle("t6", 300);
    check("t6_xfer_count", xlog.size() - base, 4);

    // All four requesters hold 2-byte packets; R0 has a second packet queued
    base = xlog.size();
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    exp_grant.push_back(2);
    exp_grant.push_back(3);
    exp_grant.push_back(0);
    send(0, 2, 'h0A, 1'b1);
    send(1, 2, 'h1A, 1'b1);
    send(2, 2, 'h2A, 1'b1);
    send(3, 2, 'h3A, 1'b1);
    send(0, 2, 'h0C, 1'b1);
    wait_idle("t2", 500);
    check("t2_xfer_count", xlog.size() - base, 10);
    if (xlog.size() >= base + 10) begin
      for (int k = 0; k < 10; k++) check($sformatf("t2_order_%0d", k), xlog[base+k].id, ids[k]);
      for (int p = 0; p < 5; p++)
        check($sformatf("t2_pair_%0d", p), xlog[base+2*p+1].cyc - xlog[base+2*p].cyc, 1);
      for (int p = 0; p < 4; p++)
        check($sformatf("t2_spacing_%0d", p), xlog[base+2*p+2].cyc - xlog[base+2*p+1].cyc, 18);
    end

    check("end_pending", pending(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
